// File: rtl/raizing_gfx_arb_pkg.sv
// Shared constants, FSM state type and small helpers for the graphics ROM arbiter.
// Optional RAIZING_GFX_ARB_OBJPRI_EN gives OBJ fixed priority over the scroll layers.
package raizing_gfx_arb_pkg;

  localparam int unsigned NREQ = 4;

  localparam logic [1:0] OBJ  = 2'd0;
  localparam logic [1:0] SCR0 = 2'd1;
  localparam logic [1:0] SCR1 = 2'd2;
  localparam logic [1:0] SCR2 = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } state_e;

  // Successor within the SCR0..SCR2 ring, used when OBJ sits outside the rotation.
  function automatic logic [1:0] next_scr(logic [1:0] idx);
    return (idx == SCR2) ? SCR0 : idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_idx(logic [NREQ-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) r = r | 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/raizing_gfx_arb_rr.sv
// Combinational round-robin picker: first pending requester at or after the pointer.
// With RAIZING_GFX_ARB_OBJPRI_EN, OBJ wins outright and only SCR0..SCR2 rotate.
module raizing_gfx_arb_rr
  import raizing_gfx_arb_pkg::*;
(
  input  logic [NREQ-1:0] pend_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            vld_o
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
`ifdef RAIZING_GFX_ARB_OBJPRI_EN
    if (pend_i[OBJ]) begin
      gnt_o[OBJ] = 1'b1;
      found      = 1'b1;
    end
    // A pointer left at OBJ (reset value) starts the scroll ring at SCR0.
    idx = (ptr_i == OBJ) ? SCR0 : ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (!found && pend_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = next_scr(idx);
    end
`else
    idx = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && pend_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = idx + 2'd1;
    end
`endif
    vld_o = found;
  end

endmodule

// File: rtl/raizing_gfx_arb.sv
// Four-way arbiter sharing one graphics ROM port among OBJ and three scroll layers.
// Define RAIZING_GFX_ARB_OBJPRI_EN to give OBJ fixed priority over the scroll layers.
module raizing_gfx_arb
  import raizing_gfx_arb_pkg::*;
#(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      REQ_CS,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  output logic [NREQ-1:0]      REQ_OK,
  output logic [NREQ*DW-1:0]   REQ_DATA,
  output logic                 ROM_CS,
  output logic [AW-1:0]        ROM_ADDR,
  input  logic                 ROM_OK,
  input  logic [DW-1:0]        ROM_DATA
);

  state_e          state_q;
  logic [1:0]      gnt_idx_q;
  logic [1:0]      ptr_q;
  logic            rom_cs_q;
  logic [AW-1:0]   rom_addr_q;
  logic [NREQ-1:0] ok_q;
  logic [DW-1:0]   data_q    [NREQ];
  logic [AW-1:0]   ok_addr_q [NREQ];

  logic [AW-1:0]   req_addr  [NREQ];
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] ok_keep;
  logic [NREQ-1:0] gnt;
  logic            gnt_vld;
  logic [1:0]      gnt_idx;
  logic            hit;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_addr[i]             = REQ_ADDR[i*AW +: AW];
    assign REQ_DATA[i*DW +: DW]    = data_q[i];
  end

  always_comb begin
    pend    = '0;
    ok_keep = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]    = REQ_CS[i] && !ok_q[i] && !(state_q == StIssue && gnt_idx_q == 2'(i));
      ok_keep[i] = REQ_CS[i] && (req_addr[i] == ok_addr_q[i]);
    end
  end

  raizing_gfx_arb_rr u_rr (
    .pend_i (pend),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  assign gnt_idx = onehot_idx(gnt);
  // Data is only delivered if the requester still wants the very address fetched.
  assign hit     = REQ_CS[gnt_idx_q] && (req_addr[gnt_idx_q] == rom_addr_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      gnt_idx_q  <= OBJ;
      ptr_q      <= OBJ;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      ok_q       <= '0;
      for (int i = 0; i < NREQ; i++) begin
        data_q[i]    <= '0;
        ok_addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!ok_keep[i]) ok_q[i] <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (gnt_vld) begin
            gnt_idx_q  <= gnt_idx;
            rom_addr_q <= req_addr[gnt_idx];
            rom_cs_q   <= 1'b1;
            state_q    <= StIssue;
`ifdef RAIZING_GFX_ARB_OBJPRI_EN
            if (gnt_idx != OBJ) ptr_q <= next_scr(gnt_idx);
`else
            ptr_q <= gnt_idx + 2'd1;
`endif
          end
        end
        StIssue: begin
          if (ROM_OK) begin
            rom_cs_q <= 1'b0;
            state_q  <= StGap;
            if (hit) begin
              data_q[gnt_idx_q]    <= ROM_DATA;
              ok_q[gnt_idx_q]      <= 1'b1;
              ok_addr_q[gnt_idx_q] <= rom_addr_q;
            end
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ROM_CS   = rom_cs_q;
  assign ROM_ADDR = rom_addr_q;
  assign REQ_OK   = ok_q;

endmodule

// File: tb/tb_raizing_gfx_arb.sv
// Directed bench for raizing_gfx_arb with a latency-programmable ROM model and
// grant/data scoreboards; honours RAIZING_GFX_ARB_OBJPRI_EN for expected grant order.
module tb_raizing_gfx_arb;
  import raizing_gfx_arb_pkg::*;

  localparam int AW = 22;
  localparam int DW = 32;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [3:0]         REQ_CS;
  logic [4*AW-1:0]    REQ_ADDR;
  logic [3:0]         REQ_OK;
  logic [4*DW-1:0]    REQ_DATA;
  logic               ROM_CS;
  logic [AW-1:0]      ROM_ADDR;
  logic               ROM_OK;
  logic [DW-1:0]      ROM_DATA;

  int checks = 0;
  int errors = 0;
  int rom_lat = 2;
  int rom_cnt = 0;

  logic [AW-1:0] exp_gnt[$];
  int            exp_idx[$];
  logic [DW-1:0] exp_dat[$];
  logic          cs_prev = 1'b0;
  logic [3:0]    ok_prev = 4'b0;

  raizing_gfx_arb #(.AW(AW), .DW(DW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ_CS   (REQ_CS),
    .REQ_ADDR (REQ_ADDR),
    .REQ_OK   (REQ_OK),
    .REQ_DATA (REQ_DATA),
    .ROM_CS   (ROM_CS),
    .ROM_ADDR (ROM_ADDR),
    .ROM_OK   (ROM_OK),
    .ROM_DATA (ROM_DATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] rom_f(logic [AW-1:0] a);
    if (a == 22'h12345) return 32'hDEADBEEF;
    return 32'hA501_0000 ^ 32'(a);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_req(int i, logic cs, logic [AW-1:0] a);
    REQ_CS[i]            = cs;
    REQ_ADDR[i*AW +: AW] = a;
  endtask

  task automatic expect_xfer(int i, logic [AW-1:0] a);
    exp_gnt.push_back(a);
    exp_idx.push_back(i);
    exp_dat.push_back(rom_f(a));
  endtask

  task automatic wait_ok(logic [3:0] m, int lim, string tag);
    int n = 0;
    while (((REQ_OK & m) != m) && n < lim) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(REQ_OK & m), 64'(m));
  endtask

  // ROM model: ROM_OK pulses for one cycle, rom_lat cycles after ROM_CS first appears.
  always @(posedge CLK) begin
    #1;
    if (ROM_OK || !ROM_CS) begin
      ROM_OK  = 1'b0;
      rom_cnt = 0;
    end else begin
      rom_cnt++;
      if (rom_cnt > rom_lat) begin
        ROM_OK   = 1'b1;
        ROM_DATA = rom_f(ROM_ADDR);
      end
    end
  end

  // Scoreboard: every fresh ROM_CS and every rising REQ_OK is matched against the queues.
  always @(posedge CLK) begin
    #1;
    if (ROM_CS && !cs_prev) begin
      if (exp_gnt.size() == 0) chk("grant_unexpected", 64'(ROM_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("grant_addr", 64'(ROM_ADDR), 64'(exp_gnt.pop_front()));
    end
    for (int i = 0; i < 4; i++) begin
      if (REQ_OK[i] && !ok_prev[i]) begin
        if (exp_idx.size() == 0) begin
          chk("ok_unexpected", 64'(i), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("ok_idx", 64'(i), 64'(exp_idx.pop_front()));
          chk("ok_data", 64'(REQ_DATA[i*DW +: DW]), 64'(exp_dat.pop_front()));
          chk("ok_rom_cs_low", 64'(ROM_CS), 64'd0);
        end
      end
    end
    cs_prev = ROM_CS;
    ok_prev = REQ_OK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET    = 1'b1;
    REQ_CS   = '0;
    REQ_ADDR = '0;
    ROM_OK   = 1'b0;
    ROM_DATA = '0;
    tick(2);
    chk("rst_rom_cs",   64'(ROM_CS),   64'd0);
    chk("rst_rom_addr", 64'(ROM_ADDR), 64'd0);
    chk("rst_req_ok",   64'(REQ_OK),   64'd0);

    // Single OBJ request, ROM_OK two cycles after ROM_CS.
    RESET = 1'b0;
    set_req(0, 1'b1, 22'h12345);
    expect_xfer(0, 22'h12345);
    tick;
    chk("c1_rom_cs",   64'(ROM_CS),   64'd1);
    chk("c1_rom_addr", 64'(ROM_ADDR), 64'h12345);
    tick;
    chk("c2_req_ok",   64'(REQ_OK[0]), 64'd0);
    tick;
    chk("c3_req_ok",   64'(REQ_OK[0]), 64'd0);
    chk("c3_rom_cs",   64'(ROM_CS),    64'd1);
    tick;
    chk("c4_req_ok",   64'(REQ_OK[0]),       64'd1);
    chk("c4_req_data", 64'(REQ_DATA[31:0]),  64'hDEADBEEF);
    chk("c4_gap_cs",   64'(ROM_CS),          64'd0);
    tick(3);
    chk("ok_hold",     64'(REQ_OK[0]), 64'd1);
    chk("no_regrant",  64'(ROM_CS),    64'd0);
    set_req(0, 1'b0, 22'h12345);
    tick;
    chk("ok_clear_cs", 64'(REQ_OK[0]),      64'd0);
    chk("data_hold",   64'(REQ_DATA[31:0]), 64'hDEADBEEF);

    // All four requesting from pointer 0.
    RESET = 1'b1;
    tick;
    chk("rst_data_zero", REQ_DATA[63:0], 64'd0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 22'h300 + 22'(i * 16));
      expect_xfer(i, 22'h300 + 22'(i * 16));
    end
    wait_ok(4'hF, 80, "all4_ok");
    tick(2);
    chk("all4_hold", 64'(REQ_OK), 64'hF);
    chk("all4_idle", 64'(ROM_CS), 64'd0);
    set_req(1, 1'b1, 22'h3F0);
    expect_xfer(1, 22'h3F0);
    tick;
    chk("ok_clear_addr", 64'(REQ_OK), 64'b1101);
    wait_ok(4'hF, 30, "scr0_reload");
    REQ_CS = '0;
    tick;
    chk("all_clear", 64'(REQ_OK), 64'd0);

    // SCR1 granted first, OBJ arrives mid-transfer.
    RESET = 1'b1;
    tick;
    RESET   = 1'b0;
    rom_lat = 3;
    set_req(2, 1'b1, 22'h2A0);
    set_req(3, 1'b1, 22'h3B0);
    expect_xfer(2, 22'h2A0);
    tick;
    chk("scr1_first", 64'(ROM_ADDR), 64'h2A0);
    set_req(0, 1'b1, 22'h0C0);
`ifdef RAIZING_GFX_ARB_OBJPRI_EN
    expect_xfer(0, 22'h0C0);
    expect_xfer(3, 22'h3B0);
`else
    expect_xfer(3, 22'h3B0);
    expect_xfer(0, 22'h0C0);
`endif
    wait_ok(4'b1101, 60, "late_obj_ok");
    REQ_CS = '0;
    tick;

    // SCR0 moves its address while in flight: first word must be dropped.
    rom_lat = 4;
    set_req(1, 1'b1, 22'h100);
    exp_gnt.push_back(22'h100);
    tick;
    chk("scr0_first_addr", 64'(ROM_ADDR), 64'h100);
    set_req(1, 1'b1, 22'h200);
    expect_xfer(1, 22'h200);
    tick(5);
    chk("discard_ok", 64'(REQ_OK[1]), 64'd0);
    wait_ok(4'b0010, 30, "scr0_retry");
    REQ_CS = '0;
    tick;

    // Reset during ISSUE aborts the transfer; OBJ is re-granted afterwards.
    set_req(0, 1'b1, 22'h55);
    exp_gnt.push_back(22'h55);
    tick;
    chk("pre_rst_cs", 64'(ROM_CS), 64'd1);
    tick;
    RESET = 1'b1;
    expect_xfer(0, 22'h55);
    tick;
    chk("mid_rst_cs",   64'(ROM_CS),   64'd0);
    chk("mid_rst_ok",   64'(REQ_OK),   64'd0);
    chk("mid_rst_addr", 64'(ROM_ADDR), 64'd0);
    tick;
    chk("rst_no_grant", 64'(ROM_CS), 64'd0);
    RESET = 1'b0;
    tick;
    chk("regrant_cs", 64'(ROM_CS), 64'd1);
    wait_ok(4'b0001, 30, "regrant_ok");
    REQ_CS = '0;
    tick(3);

    chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
    chk("ok_queue_empty",  64'(exp_idx.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
